// File: rtl/pe2ddr_wr_addr_gen.sv
// pe2ddr_wr_addr_gen: turns one strided transfer descriptor (start address,
// row bytes, row stride, row count) into AXI4 write-address bursts limited by
// MAX_BEATS and the 4 KB boundary, and counts outstanding B responses.
//
// state  | meaning
// IDLE   | waiting for start; done high
// CALC   | size the next burst from rem, MAX_BEATS and 4 KB distance
// ADDR   | present awaddr/awlen, wait for handshake (throttled by MAX_OUTST)
// DRAIN  | all bursts issued, wait for outstanding B responses
module pe2ddr_wr_addr_gen #(
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 16,
  parameter int DATA_BYTES = 32,
  parameter int MAX_BEATS  = 16,
  parameter int MAX_OUTST  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  input  logic [DDR_ADDR_W-1:0] st_addr,
  input  logic [BURST_W-1:0]    burst,
  input  logic [DDR_ADDR_W-1:0] step,
  input  logic [BURST_W-1:0]    burst_num,
  output logic [DDR_ADDR_W-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  input  logic                  bvalid,
  input  logic [1:0]            bresp,
  output logic                  bready,
  output logic                  err
);

  localparam int SH = $clog2(DATA_BYTES);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int LW = (BURST_W > 13) ? BURST_W : 13;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ADDR, S_DRAIN} state_t;

  state_t                r_state;
  logic [DDR_ADDR_W-1:0] r_row_addr;
  logic [DDR_ADDR_W-1:0] r_cur_addr;
  logic [DDR_ADDR_W-1:0] r_step;
  logic [BURST_W-1:0]    r_row_cnt;
  logic [BURST_W-1:0]    r_rows;
  logic [BURST_W-1:0]    r_row_beats;
  logic [BURST_W-1:0]    r_rem;
  logic [LW-1:0]         r_len;
  logic [OW-1:0]         r_outst;
  logic [DDR_ADDR_W-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic                  r_awvalid;
  logic                  r_done;
  logic                  r_err;
  logic                  r_bready;

  logic                  w_aw_hs;
  logic                  w_b_acc;
  logic [OW-1:0]         w_outst_nxt;
  logic                  w_outst_ok;
  logic [BURST_W-1:0]    w_start_beats;
  logic [12:0]           w_4k_room;
  logic [LW-1:0]         w_4k_beats;
  logic [LW-1:0]         w_len;
  logic [BURST_W-1:0]    w_rem_left;
  logic [DDR_ADDR_W-1:0] w_cur_adv;
  logic [DDR_ADDR_W-1:0] w_row_next;
  logic                  w_more_rows;

  assign w_aw_hs       = r_awvalid & awready;
  // A response with nothing outstanding is ignored entirely.
  assign w_b_acc       = bvalid & r_bready & (r_outst != '0);
  assign w_start_beats = burst >> SH;
  assign w_4k_room     = 13'h1000 - {1'b0, r_cur_addr[11:0]};
  assign w_4k_beats    = LW'(w_4k_room >> SH);
  assign w_rem_left    = r_rem - BURST_W'(r_len);
  assign w_cur_adv     = r_cur_addr + (DDR_ADDR_W'(r_len) << SH);
  assign w_row_next    = r_row_addr + r_step;
  assign w_more_rows   = ((BURST_W+1)'(r_row_cnt) + (BURST_W+1)'(1)) < (BURST_W+1)'(r_rows);
  assign w_outst_ok    = w_outst_nxt < OW'(MAX_OUTST);

  // Outstanding count after this cycle's AW handshake and B acceptance.
  always_comb begin
    w_outst_nxt = r_outst;
    if (w_aw_hs && !w_b_acc)
      w_outst_nxt = r_outst + OW'(1);
    else if (!w_aw_hs && w_b_acc)
      w_outst_nxt = r_outst - OW'(1);
  end

  // Burst length: smallest of remaining beats, MAX_BEATS and beats to the 4 KB line.
  always_comb begin
    w_len = LW'(r_rem);
    if (w_len > LW'(MAX_BEATS))
      w_len = LW'(MAX_BEATS);
    if (w_len > w_4k_beats)
      w_len = w_4k_beats;
    // An unaligned address right below the 4 KB line must still make progress.
    if (w_len == '0)
      w_len = LW'(1);
  end

  // Main sequencer with registered AXI outputs and response tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row_addr  <= '0;
      r_cur_addr  <= '0;
      r_step      <= '0;
      r_row_cnt   <= '0;
      r_rows      <= '0;
      r_row_beats <= '0;
      r_rem       <= '0;
      r_len       <= '0;
      r_outst     <= '0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_awvalid   <= 1'b0;
      r_done      <= 1'b1;
      r_err       <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      r_bready <= 1'b1;
      r_outst  <= w_outst_nxt;
      if (w_b_acc && (bresp != 2'b00))
        r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_addr  <= st_addr;
            r_cur_addr  <= st_addr;
            r_step      <= step;
            r_rows      <= burst_num;
            r_row_cnt   <= '0;
            r_row_beats <= w_start_beats;
            r_rem       <= w_start_beats;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            if ((burst_num == '0) || (w_start_beats == '0))
              r_state <= S_DRAIN;
            else
              r_state <= S_CALC;
          end else begin
            r_done <= 1'b1;
          end
        end

        S_CALC: begin
          r_awaddr  <= r_cur_addr;
          r_awlen   <= 8'(w_len - LW'(1));
          r_len     <= w_len;
          r_awvalid <= w_outst_ok;
          r_state   <= S_ADDR;
        end

        S_ADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            if (w_rem_left != '0) begin
              r_cur_addr <= w_cur_adv;
              r_rem      <= w_rem_left;
              r_state    <= S_CALC;
            end else if (w_more_rows) begin
              r_row_cnt  <= r_row_cnt + BURST_W'(1);
              r_row_addr <= w_row_next;
              r_cur_addr <= w_row_next;
              r_rem      <= r_row_beats;
              r_state    <= S_CALC;
            end else begin
              r_cur_addr <= w_cur_adv;
              r_rem      <= w_rem_left;
              r_state    <= S_DRAIN;
            end
          end else begin
            // Only ever drops at the limit before the first assertion of a burst.
            r_awvalid <= w_outst_ok;
          end
        end

        S_DRAIN: begin
          if (r_outst == '0)
            r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign awaddr  = r_awaddr;
  assign awlen   = r_awlen;
  assign awvalid = r_awvalid;
  assign done    = r_done;
  assign err     = r_err;
  assign bready  = r_bready;

endmodule

// File: tb/tb_pe2ddr_wr_addr_gen.sv
// Bench for pe2ddr_wr_addr_gen: directed cases plus randomized descriptors,
// checked against a row/burst splitting model built from plain arithmetic.
module tb_pe2ddr_wr_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [31:0] st_addr;
  logic [15:0] burst;
  logic [31:0] step;
  logic [15:0] burst_num;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  int b_cnt    = 0;
  int drop     = 0;
  int aw_mode  = 0;      // 0: always ready, 1: random, 2: never ready
  int b_budget = 0;      // number of B responses still allowed
  bit b_rand   = 1'b0;
  int b_err_left = 0;    // next N responses carry SLVERR
  logic [31:0] obs_addr [0:1023];
  logic [7:0]  obs_len  [0:1023];
  logic [31:0] exp_addr [$];
  logic [7:0]  exp_len  [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [7:0]  prev_len   = '0;

  pe2ddr_wr_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .st_addr(st_addr), .burst(burst), .step(step), .burst_num(burst_num),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected bursts: walk each row, cut at MAX_BEATS (16) and at each 4 KB line.
  task automatic build_exp(input logic [31:0] a0, input logic [15:0] bl,
                           input logic [31:0] st, input logic [15:0] rows);
    int unsigned beats, left, room, n;
    logic [31:0] a;
    exp_addr.delete();
    exp_len.delete();
    beats = int'(bl) / 32;
    if (beats == 0) return;
    for (int r = 0; r < int'(rows); r++) begin
      a = a0 + st * r;
      left = beats;
      while (left > 0) begin
        room = (4096 - (a % 4096)) / 32;
        n = left;
        if (n > 16) n = 16;
        if (n > room) n = room;
        exp_addr.push_back(a);
        exp_len.push_back(8'(n - 1));
        a = a + n * 32;
        left = left - n;
      end
    end
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          chk("aw_hold_valid", awvalid, 1'b1);
          chk("aw_hold_addr", awaddr, prev_addr);
          chk("aw_hold_len", awlen, prev_len);
        end
        if (awvalid)
          chk("outst_limit", (hs_cnt - b_cnt - drop) < 8, 1'b1);
        prev_stall = awvalid && !awready;
        prev_addr  = awaddr;
        prev_len   = awlen;
        if (awvalid && awready) begin
          obs_addr[hs_cnt % 1024] = awaddr;
          obs_len[hs_cnt % 1024]  = awlen;
          hs_cnt++;
        end
        if (bvalid && bready)
          b_cnt++;
      end else begin
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic aw_loop();
    forever begin
      @(posedge clk);
      #1;
      if (aw_mode == 0)      awready = 1'b1;
      else if (aw_mode == 1) awready = 1'($urandom_range(0, 1));
      else                   awready = 1'b0;
    end
  endtask

  task automatic b_loop();
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && b_budget > 0 && (hs_cnt - b_cnt - drop) > 0 &&
          (!b_rand || $urandom_range(0, 2) != 0)) begin
        bvalid = 1'b1;
        bresp  = (b_err_left > 0) ? 2'b10 : 2'b00;
        if (b_err_left > 0) b_err_left--;
        b_budget--;
      end else begin
        bvalid = 1'b0;
        bresp  = 2'b00;
      end
    end
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] bl,
                             input logic [31:0] st, input logic [15:0] rows);
    @(posedge clk);
    #1;
    st_addr = a; burst = bl; step = st; burst_num = rows; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic compare_bursts(input string tag, input int base, input int bbase);
    int n_obs = hs_cnt - base;
    chk({tag, "_nbursts"}, n_obs, exp_addr.size());
    chk({tag, "_nresp"}, b_cnt - bbase, exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < n_obs; k++) begin
      chk({tag, "_addr"}, obs_addr[(base + k) % 1024], exp_addr[k]);
      chk({tag, "_len"}, obs_len[(base + k) % 1024], exp_len[k]);
    end
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] a, input logic [15:0] bl,
                          input logic [31:0] st, input logic [15:0] rows);
    int base  = hs_cnt;
    int bbase = b_cnt;
    build_exp(a, bl, st, rows);
    pulse_start(a, bl, st, rows);
    chk({tag, "_done_t1"}, done, 1'b0);
    chk({tag, "_err_clr"}, err, 1'b0);
    if (exp_addr.size() > 0) begin
      chk({tag, "_awvalid_t1"}, awvalid, 1'b0);
      @(posedge clk);
      #1;
      chk({tag, "_awvalid_t2"}, awvalid, 1'b1);
      chk({tag, "_awaddr_t2"}, awaddr, exp_addr[0]);
    end
    wait_done(3000);
    compare_bursts(tag, base, bbase);
  endtask

  initial begin
    int base, bbase;
    rst_n = 1'b0; start = 1'b0; st_addr = '0; burst = '0; step = '0; burst_num = '0;
    awready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    fork
      mon_loop();
      aw_loop();
      b_loop();
    join_none

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 1'b1);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_awlen", awlen, 8'h0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_bready", bready, 1'b1);
    chk("idle_done", done, 1'b1);

    // directed cases with immediate responses
    aw_mode = 0; b_rand = 1'b0; b_budget = 1000000;
    run_xfer("three_rows", 32'h1000, 16'h0080, 32'h400, 16'd3);
    run_xfer("maxbeats", 32'h0, 16'h0300, 32'h0, 16'd1);
    run_xfer("split4k", 32'h0FC0, 16'h0080, 32'h0, 16'd1);

    // response backpressure: outstanding limit of 8
    b_budget = 0;
    base = hs_cnt; bbase = b_cnt;
    build_exp(32'h0, 16'h0020, 32'h100, 16'd12);
    pulse_start(32'h0, 16'h0020, 32'h100, 16'd12);
    repeat (40) @(posedge clk);
    #1;
    chk("bp_hs8", hs_cnt - base, 8);
    chk("bp_awvalid_low", awvalid, 1'b0);
    chk("bp_done_low", done, 1'b0);
    b_budget = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_hs9", hs_cnt - base, 9);
    chk("bp_awvalid_low2", awvalid, 1'b0);
    chk("bp_done_low2", done, 1'b0);
    b_budget = 1000000;
    wait_done(3000);
    compare_bursts("bp", base, bbase);

    // empty descriptors: done low for exactly two cycles
    base = hs_cnt;
    pulse_start(32'h5000, 16'h0080, 32'h40, 16'd0);
    chk("zero_rows_t1", done, 1'b0);
    @(posedge clk); #1;
    chk("zero_rows_t2", done, 1'b0);
    @(posedge clk); #1;
    chk("zero_rows_t3", done, 1'b1);
    chk("zero_rows_noaw", hs_cnt - base, 0);
    pulse_start(32'h5000, 16'h001F, 32'h40, 16'd2);
    chk("zero_beats_t1", done, 1'b0);
    @(posedge clk); #1;
    chk("zero_beats_t2", done, 1'b0);
    @(posedge clk); #1;
    chk("zero_beats_t3", done, 1'b1);
    chk("zero_beats_noaw", hs_cnt - base, 0);

    // start while busy is ignored; error response is sticky
    b_err_left = 1;
    base = hs_cnt; bbase = b_cnt;
    build_exp(32'h2000, 16'h0100, 32'h800, 16'd2);
    pulse_start(32'h2000, 16'h0100, 32'h800, 16'd2);
    repeat (2) @(posedge clk);
    pulse_start(32'h9000, 16'h0040, 32'h40, 16'd5);
    wait_done(3000);
    compare_bursts("busy_ign", base, bbase);
    chk("err_set", err, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err, 1'b1);
    run_xfer("err_clear", 32'h3000, 16'h0040, 32'h0, 16'd1);

    // reset while a burst is stalled
    aw_mode = 2;
    pulse_start(32'h3000, 16'h0040, 32'h0, 16'd1);
    @(posedge clk); #1;
    chk("stall_awvalid", awvalid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_awvalid", awvalid, 1'b0);
    chk("midrst_done", done, 1'b1);
    chk("midrst_awaddr", awaddr, 32'h0);
    rst_n = 1'b1;
    aw_mode = 0;
    drop = hs_cnt - b_cnt;
    run_xfer("after_rst", 32'h4000, 16'h0060, 32'h200, 16'd2);

    // randomized descriptors with random ready/response timing
    aw_mode = 1; b_rand = 1'b1;
    for (int it = 0; it < 25; it++) begin
      logic [31:0] ra, rs;
      logic [15:0] rb, rn;
      ra = $urandom & 32'hFFFF_FFE0;
      rb = 16'($urandom_range(0, 16'h0800));
      rs = $urandom & 32'h0000_3FE0;
      rn = 16'($urandom_range(0, 4));
      run_xfer("rand", ra, rb, rs, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe2ddr_wr_addr_gen.md
# pe2ddr_wr_addr_gen

Write-address generator for the PE-to-DDR result path; one instance sits on each DDR write port (ddr1, ddr2) directly downstream of the PE-to-DDR configuration stage. It accepts one strided transfer descriptor per start pulse: start address, row length in bytes, row stride and row count. It breaks the descriptor into AXI4 write-address bursts that respect a maximum burst length and the 4 KB boundary, and tracks write responses. It reports completion on a level `done` signal.

## Interface
- DDR_ADDR_W, 32, address width
- BURST_W, 16, width of byte-length and row-count fields
- DATA_BYTES, 32, bytes per data beat (power of two)
- MAX_BEATS, 16, max beats per AXI burst (≤256, power of two)
- MAX_OUTST, 8, max outstanding bursts awaiting B response

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low
- start  in  1  one-cycle descriptor strobe
- done  out  1  level: high when idle with nothing outstanding
- st_addr  in  DDR_ADDR_W  byte address of row 0
- burst  in  BURST_W  row length in bytes; low log2(DATA_BYTES) bits ignored
- step  in  DDR_ADDR_W  byte stride between row starts
- burst_num  in  BURST_W  number of rows
- awaddr  out  DDR_ADDR_W  burst address
- awlen  out  8  beats-1
- awvalid  out  1  address valid
- awready  in  1  address accepted
- bvalid  in  1  write response valid
- bresp  in  2  write response code
- bready  out  1  constant 1 out of reset
- err  out  1  sticky: some bresp ≠ 0; cleared by the next accepted start

## Operation
- States: IDLE, CALC, ADDR, DRAIN.
- IDLE: `start` latches all descriptor fields, sets row_addr=cur_addr=st_addr, row_cnt=0, rem=burst>>log2(DATA_BYTES), clears err, goes to CALC. `start` is ignored in any state other than IDLE.
- burst_num==0 or rem==0 at start: go directly to DRAIN; no bursts are issued.
- CALC: len = min(rem, MAX_BEATS, (4096 − cur_addr[11:0]) >> log2(DATA_BYTES)). Load awaddr=cur_addr and awlen=len−1, then go to ADDR.
- ADDR: awvalid is high only while outstanding < MAX_OUTST. On awready&&awvalid:
  - outstanding++
  - cur_addr += len*DATA_BYTES
  - rem −= len
- After the handshake in ADDR:
  - rem≠0: go to CALC.
  - rem==0 and row_cnt+1 < burst_num: row_cnt++, row_addr += step, cur_addr = row_addr+step, rem reloaded, go to CALC.
  - Otherwise: go to DRAIN.
- DRAIN: wait for outstanding==0, then go to IDLE.
- bvalid (bready=1): outstanding−−; bresp≠0 sets err.
- Simultaneous AW handshake and bvalid: outstanding is unchanged.
- Address arithmetic wraps modulo 2^DDR_ADDR_W; no overflow detection.
- outstanding counter width: clog2(MAX_OUTST+1). A bvalid with outstanding==0 is ignored.

## Timing
- Reset values: done=1, awvalid=0, awaddr=0, awlen=0, err=0, bready=1 (bready goes high the first cycle after rst_n deasserts), state=IDLE, outstanding=0.
- start sampled at cycle t: done=0 from t+1, CALC at t+1, first awvalid at t+2.
- awaddr and awlen are stable while awvalid=1 and awready=0.
- Next burst awvalid comes 2 cycles after the previous handshake (CALC bubble).
- done rises the cycle after DRAIN sees outstanding==0.
- burst_num==0 case: done is low for exactly 2 cycles (t+1, t+2).
- rst_n low mid-transfer: all state returns to reset values on the next edge. In-flight responses are dropped.

## Test plan
- st_addr=0x1000, burst=0x80, step=0x400, burst_num=3, awready=1, immediate B: three bursts at 0x1000/0x1400/0x1800, each awlen=3. done low from t+1 and returns high after the third B.
- burst=0x300, burst_num=1, st_addr=0: bursts at 0x0 with awlen=15, then at 0x200 with awlen=7.
- st_addr=0x0FC0, burst=0x80, burst_num=1: bursts at 0x0FC0 with awlen=1, then at 0x1000 with awlen=1 (4 KB split).
- bvalid held low, burst=0x20, burst_num=12: exactly 8 AW handshakes, then awvalid stays 0. After releasing 1 B, one more AW handshake; done rises only after 12 B responses.
- burst_num=0: no awvalid, done=0 for 2 cycles. A second start during busy is ignored; a bresp=2 sets err, which clears on the next start.
- rst_n low while awvalid=1 with awready=0: next cycle awvalid=0, done=1; a fresh start then runs normally.
